// File: rtl/sram_controller.sv
// sram_controller: responder for cache block reads (64-bit) and word writes
// (32-bit), sequenced onto a 256Kx16 asynchronous SRAM as 16-bit accesses.
module sram_controller #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [17:0] address,
    input  logic [31:0] wdata,
    input  logic        r_en,
    input  logic        w_en,
    output logic [63:0] rdata,
    output logic        ready,
    output logic [17:0] SRAM_ADDR,
    inout  wire  [15:0] SRAM_DQ,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Last sub-cycle of one 16-bit access.
    localparam logic [2:0] C_LAST = 3'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [1:0]  k_q, k_d;
    logic [2:0]  c_q, c_d;
    logic [17:2] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [63:0] rdata_q, rdata_d;
    logic [17:0] sram_addr_q, sram_addr_d;
    logic        dq_oe;
    logic [15:0] dq_out;

    // Byte offset within a word never selects anything: reads fetch the
    // whole block and writes always cover the whole word.
    logic unused_addr_bits;
    assign unused_addr_bits = ^address[1:0];

    // State, counters, latched request and SRAM address register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            c_q         <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            sram_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            c_q         <= c_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            sram_addr_q <= sram_addr_d;
        end
    end

    // Next-state sequencing, SRAM strobes and requester handshake.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        c_d         = c_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        sram_addr_d = sram_addr_q;
        ready       = 1'b0;
        SRAM_CE_N   = 1'b1;
        SRAM_OE_N   = 1'b1;
        SRAM_WE_N   = 1'b1;
        dq_oe       = 1'b0;
        dq_out      = k_q[0] ? wdata_q[31:16] : wdata_q[15:0];

        case (state_q)
            IDLE: begin
                ready = ~r_en & ~w_en;
                k_d   = '0;
                c_d   = '0;
                if (w_en) begin
                    state_d     = WRITE;
                    addr_d      = address[17:2];
                    wdata_d     = wdata;
                    sram_addr_d = {1'b0, address[17:2], 1'b0};
                end else if (r_en) begin
                    state_d     = READ;
                    addr_d      = address[17:2];
                    sram_addr_d = {1'b0, address[17:3], 2'b00};
                end
            end

            READ: begin
                SRAM_CE_N = 1'b0;
                SRAM_OE_N = 1'b0;
                if (c_q == C_LAST) begin
                    c_d = '0;
                    case (k_q)
                        2'd0:    rdata_d[15:0]  = SRAM_DQ;
                        2'd1:    rdata_d[31:16] = SRAM_DQ;
                        2'd2:    rdata_d[47:32] = SRAM_DQ;
                        default: rdata_d[63:48] = SRAM_DQ;
                    endcase
                    if (k_q == 2'd3) begin
                        state_d = DONE;
                        k_d     = '0;
                    end else begin
                        k_d         = k_q + 2'd1;
                        sram_addr_d = {1'b0, addr_q[17:3], k_d};
                    end
                end else begin
                    c_d = c_q + 3'd1;
                end
            end

            WRITE: begin
                SRAM_CE_N = 1'b0;
                dq_oe     = 1'b1;
                // WE_N returns high on the last sub-cycle so address and
                // data are still held when the SRAM latches the write.
                SRAM_WE_N = (c_q == C_LAST);
                if (c_q == C_LAST) begin
                    c_d = '0;
                    if (k_q[0]) begin
                        state_d = DONE;
                        k_d     = '0;
                    end else begin
                        k_d         = 2'd1;
                        sram_addr_d = {1'b0, addr_q[17:2], 1'b1};
                    end
                end else begin
                    c_d = c_q + 3'd1;
                end
            end

            DONE: begin
                ready   = 1'b1;
                state_d = IDLE;
                k_d     = '0;
                c_d     = '0;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign SRAM_DQ   = dq_oe ? dq_out : 'z;
    assign SRAM_ADDR = sram_addr_q;
    assign rdata     = rdata_q;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

endmodule
